// File: rtl/sl_pkg.sv
// Shared types and helpers for the queued SL transmitter.
package sl_pkg;

  localparam int unsigned SL_MAX_W = 32;

  typedef enum logic [1:0] {
    MODE8  = 2'b00,
    MODE16 = 2'b01,
    MODE24 = 2'b10,
    MODE32 = 2'b11
  } sl_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } sl_tx_state_t;

  function automatic logic [5:0] mode_len(input sl_mode_t m);
    case (m)
      MODE8:   return 6'd8;
      MODE16:  return 6'd16;
      MODE24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/sl_tx_fifo.sv
// Synchronous FIFO holding {mode, data} words for the SL transmitter.
module sl_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 34
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sl_tx_queued.sv
// Queued SL transmitter: FIFO-fed, per-word length, MSB-first serialiser.
// Define SL_TX_PARITY_EN to append an odd-parity bit after each word.
module sl_tx_queued
  import sl_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAP_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  input  logic [1:0]                   in_mode,
  output logic                         sl0,
  output logic                         sl1,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW      = $clog2(CLK_DIV+1);
  localparam int unsigned GAP_CYC = GAP_BITS * 2 * CLK_DIV;
  localparam int unsigned GW      = $clog2(GAP_CYC+1);

  logic               rdy_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [33:0]        head;

  sl_tx_state_t       state;
  logic [SL_MAX_W:0]  shreg;
  logic [5:0]         bitcnt;
  logic [PW-1:0]      phase;
  logic [GW-1:0]      gapcnt;

  sl_mode_t           hmode;
  logic [5:0]         hlen;
  logic [5:0]         nbits;
  logic [31:0]        mask;
  logic [31:0]        masked;
  logic               par;
  logic [SL_MAX_W:0]  load;

  assign in_ready = rdy_q && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && en && !empty;

  sl_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (34)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_mode, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Align the active field (plus parity) to the top of a 33-bit shift register.
  always_comb begin
    hmode  = sl_mode_t'(head[33:32]);
    hlen   = mode_len(hmode);
    mask   = (hlen == 6'd32) ? '1 : ((32'd1 << hlen) - 32'd1);
    masked = head[31:0] & mask;
`ifdef SL_TX_PARITY_EN
    par    = ~(^masked);
    nbits  = hlen + 6'd1;
`else
    par    = 1'b0;
    nbits  = hlen;
`endif
    load   = {masked, par} << (6'd32 - hlen);
  end

  // Line registers follow the state one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      phase  <= '0;
      gapcnt <= '0;
      sl0    <= 1'b1;
      sl1    <= 1'b1;
      busy   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      sl0   <= !((state == LOW) && !shreg[SL_MAX_W]);
      sl1   <= !((state == LOW) &&  shreg[SL_MAX_W]);
      case (state)
        IDLE: begin
          if (pop) begin
            state  <= LOW;
            shreg  <= load;
            bitcnt <= nbits - 6'd1;
            phase  <= PW'(CLK_DIV - 1);
            busy   <= 1'b1;
          end
        end
        LOW: begin
          if (phase == '0) begin
            state <= HIGH;
            phase <= PW'(CLK_DIV - 1);
            shreg <= shreg << 1;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        HIGH: begin
          if (phase == '0) begin
            if (bitcnt == '0) begin
              state  <= GAP;
              gapcnt <= GW'(GAP_CYC - 1);
            end else begin
              state  <= LOW;
              bitcnt <= bitcnt - 6'd1;
              phase  <= PW'(CLK_DIV - 1);
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        GAP: begin
          if (gapcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gapcnt <= gapcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sl_tx_queued.sv
// Self-checking bench for sl_tx_queued against a bit-list reference model.
module tb_sl_tx_queued;

  localparam int unsigned CD    = 2;
  localparam int unsigned GB    = 4;
  localparam int unsigned DEPTH = 4;
`ifdef SL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BIT_PERIOD = 2 * CD;
  localparam int WORD_TAIL  = 2 * CD * (1 + GB);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        sl0;
  logic        sl1;
  logic        busy;
  logic [2:0]  level;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sl_tx_queued #(
    .DEPTH    (DEPTH),
    .CLK_DIV  (CD),
    .GAP_BITS (GB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .sl0      (sl0),
    .sl1      (sl1),
    .busy     (busy),
    .level    (level)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
  } word_t;

  typedef struct {
    bit line;
    int start;
    int width;
  } pulse_t;

  word_t  exp_q[$];
  pulse_t obs_q[$];
  int     rise_q[$];
  int     fall_q[$];
  int     both_low = 0;
  int     starts = 0;
  logic   prev0 = 1'b1;
  logic   prev1 = 1'b1;
  logic   prevb = 1'b0;
  int     st0 = 0;
  int     st1 = 0;

  // Line monitor: records every low pulse and every busy edge.
  always @(posedge clk) begin
    #1;
    if (sl0 === 1'b0 && sl1 === 1'b0) both_low++;
    if (sl0 === 1'b0 && prev0 !== 1'b0) begin st0 = cyc; starts++; end
    if (sl0 !== 1'b0 && prev0 === 1'b0) obs_q.push_back('{1'b0, st0, cyc - st0});
    if (sl1 === 1'b0 && prev1 !== 1'b0) begin st1 = cyc; starts++; end
    if (sl1 !== 1'b0 && prev1 === 1'b0) obs_q.push_back('{1'b1, st1, cyc - st1});
    if (busy === 1'b1 && prevb !== 1'b1) rise_q.push_back(cyc);
    if (busy === 1'b0 && prevb === 1'b1) fall_q.push_back(cyc);
    prev0 = sl0;
    prev1 = sl1;
    prevb = busy;
  end

  // Reference: each word is len bits MSB first, then an odd-parity bit if enabled;
  // bits are 2*CD apart, and a queued word starts WORD_TAIL+1 after the last bit.
  task automatic score(input bit b2b, output int errs, output int npulse);
    word_t  w;
    pulse_t p;
    bit     bits[$];
    int     len;
    int     ones;
    int     prev_start;
    bit     first;
    errs   = 0;
    npulse = obs_q.size();
    first  = 1'b1;
    prev_start = 0;
    for (int wi = 0; exp_q.size() > 0; wi++) begin
      w = exp_q.pop_front();
      len = 8 * (int'(w.mode) + 1);
      ones = 0;
      bits.delete();
      for (int i = len - 1; i >= 0; i--) begin
        bits.push_back(w.data[i]);
        ones += int'(w.data[i]);
      end
      if (PAR) bits.push_back((ones % 2) == 0);
      for (int k = 0; k < bits.size(); k++) begin
        if (obs_q.size() == 0) begin
          $display("  word %0d bit %0d: no pulse observed", wi, k);
          errs++;
          continue;
        end
        p = obs_q.pop_front();
        if (p.line != bits[k]) begin
          $display("  word %0d bit %0d: line sl%0d want sl%0d", wi, k, p.line, bits[k]);
          errs++;
        end
        if (p.width != CD) begin
          $display("  word %0d bit %0d: width %0d want %0d", wi, k, p.width, CD);
          errs++;
        end
        if (!first && k > 0 && (p.start - prev_start) != BIT_PERIOD) begin
          $display("  word %0d bit %0d: spacing %0d want %0d", wi, k, p.start - prev_start, BIT_PERIOD);
          errs++;
        end
        if (!first && k == 0 && b2b && (p.start - prev_start) != WORD_TAIL + 1) begin
          $display("  word %0d: start spacing %0d want %0d", wi, p.start - prev_start, WORD_TAIL + 1);
          errs++;
        end
        prev_start = p.start;
        first = 1'b0;
      end
    end
    if (obs_q.size() != 0) begin
      $display("  %0d extra pulses observed", obs_q.size());
      errs += obs_q.size();
      obs_q.delete();
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] m, output bit ok, output int acc);
    ok  = 1'b0;
    acc = -1;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      acc = cyc + 1;
      @(posedge clk);
      exp_q.push_back('{d, m});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (busy === 1'b0 && level === 3'd0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sl0 !== 1'b1) $display("FAIL reset_sl0: got %b want 1", sl0); else passed++;
    total++; if (sl1 !== 1'b1) $display("FAIL reset_sl1: got %b want 1", sl1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_single;
    bit ok;
    int acc;
    int errs;
    int np;
    int last_start;
    int rise;
    int fall;
    en = 1'b1;
    both_low = 0;
    rise_q.delete();
    fall_q.delete();
    push_word(32'h0000_0086, 2'b00, ok, acc);
    total++; if (ok !== 1'b1) $display("FAIL single_accept: got %b want 1", ok); else passed++;
    wait_done(400, ok);
    total++; if (ok !== 1'b1) $display("FAIL single_done: timeout got %b want 1", ok); else passed++;
    last_start = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].start : -1;
    total++;
    if (obs_q.size() == 0 || obs_q[0].start !== acc + 2)
      $display("FAIL single_latency: first pulse cycle %0d want %0d", (obs_q.size() > 0) ? obs_q[0].start : -1, acc + 2);
    else passed++;
    rise = (rise_q.size() > 0) ? rise_q[0] : -1;
    fall = (fall_q.size() > 0) ? fall_q[0] : -1;
    total++; if (rise !== acc + 1) $display("FAIL single_busy_rise: got %0d want %0d", rise, acc + 1); else passed++;
    total++; if (fall !== last_start - 1 + WORD_TAIL) $display("FAIL single_busy_fall: got %0d want %0d", fall, last_start - 1 + WORD_TAIL); else passed++;
    score(1'b0, errs, np);
    total++; if (np !== (PAR ? 9 : 8)) $display("FAIL single_count: got %0d want %0d", np, PAR ? 9 : 8); else passed++;
    total++; if (errs !== 0) $display("FAIL single_stream: %0d discrepancies want 0", errs); else passed++;
  endtask

  task automatic test_all_ones;
    bit ok;
    int acc;
    int errs;
    int np;
    push_word(32'hFFFF_FFFF, 2'b11, ok, acc);
    wait_done(600, ok);
    total++; if (ok !== 1'b1) $display("FAIL ones_done: timeout got %b want 1", ok); else passed++;
    score(1'b0, errs, np);
    total++; if (np !== (PAR ? 33 : 32)) $display("FAIL ones_count: got %0d want %0d", np, PAR ? 33 : 32); else passed++;
    total++; if (errs !== 0) $display("FAIL ones_stream: %0d discrepancies want 0", errs); else passed++;
  endtask

  task automatic test_full;
    bit          ok;
    int          errs;
    int          np;
    logic [31:0] d;
    logic [1:0]  m;
    logic [2:0]  prev;
    en = 1'b0;
    both_low = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      m = 2'($urandom_range(3, 0));
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      total++;
      if (in_ready !== (i < 4)) $display("FAIL full_ready_%0d: got %b want %b", i, in_ready, i < 4); else passed++;
      @(posedge clk);
      if (i < 4) exp_q.push_back('{d, m});
      @(negedge clk);
    end
    total++; if (level !== 3'd4) $display("FAIL full_level: got %0d want 4", level); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready); else passed++;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (level !== 3'd3) $display("FAIL full_pop_no_push: level %0d want 3", level); else passed++;
    for (int e = 2; e >= 0; e--) begin
      prev = level;
      for (int t = 0; t < 400 && level === prev; t++) @(negedge clk);
      total++; if (level !== 3'(e)) $display("FAIL full_level_step: got %0d want %0d", level, e); else passed++;
    end
    wait_done(800, ok);
    total++; if (ok !== 1'b1) $display("FAIL full_done: timeout got %b want 1", ok); else passed++;
    score(1'b1, errs, np);
    total++; if (errs !== 0) $display("FAIL full_stream: %0d discrepancies want 0", errs); else passed++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit all_ok;
    int acc;
    int errs;
    int np;
    en = 1'b1;
    both_low = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_word($urandom, 2'($urandom_range(3, 0)), ok, acc);
      all_ok &= ok;
    end
    total++; if (all_ok !== 1'b1) $display("FAIL b2b_accept: got %b want 1", all_ok); else passed++;
    wait_done(1500, ok);
    total++; if (ok !== 1'b1) $display("FAIL b2b_done: timeout got %b want 1", ok); else passed++;
    score(1'b1, errs, np);
    total++; if (errs !== 0) $display("FAIL b2b_stream: %0d discrepancies want 0", errs); else passed++;
    total++; if (both_low !== 0) $display("FAIL b2b_both_low: got %0d cycles want 0", both_low); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int acc;
    int errs;
    int np;
    int s0;
    en = 1'b1;
    push_word(32'h1234_5678, 2'b11, ok, acc);
    push_word(32'h0000_00C3, 2'b00, ok, acc);
    s0 = starts;
    for (int t = 0; t < 200 && starts < s0 + 5; t++) @(negedge clk);
    total++; if (starts !== s0 + 5) $display("FAIL mid_reach_bit5: pulses %0d want %0d", starts - s0, 5); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if ({sl0, sl1} !== 2'b11) $display("FAIL mid_lines: got %b want 11", {sl0, sl1}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    total++; if (level !== 3'd0) $display("FAIL mid_level: got %0d want 0", level); else passed++;
    reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    push_word(32'h0000_5A3C, 2'b01, ok, acc);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_done(400, ok);
    en = 1'b1;
    total++; if (ok !== 1'b1) $display("FAIL mid_done: timeout got %b want 1", ok); else passed++;
    score(1'b0, errs, np);
    total++; if (np !== (PAR ? 17 : 16)) $display("FAIL mid_count: got %0d want %0d", np, PAR ? 17 : 16); else passed++;
    total++; if (errs !== 0) $display("FAIL mid_stream: %0d discrepancies want 0", errs); else passed++;
  endtask

  task automatic test_modes;
    bit ok;
    int acc;
    int errs;
    int np;
    int want;
    en = 1'b1;
    for (int m = 0; m < 3; m++) begin
      push_word(32'hFFA5_A5A5, 2'(m), ok, acc);
      wait_done(400, ok);
      want = 8 * (m + 1) + (PAR ? 1 : 0);
      score(1'b0, errs, np);
      total++; if (np !== want) $display("FAIL mode%0d_count: got %0d want %0d", m, np, want); else passed++;
      total++; if (errs !== 0) $display("FAIL mode%0d_stream: %0d discrepancies want 0", m, errs); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ones();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_modes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
